// File: rtl/regfile_read_port.sv
// Two-read / one-write register file with write-to-read bypass and a
// per-register busy scoreboard that stalls operand reads of pending writebacks.
module regfile_read_port #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  w_enable,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic                  r_req,
    input  logic [ADDR_WIDTH-1:0] r_addr_a,
    input  logic [ADDR_WIDTH-1:0] r_addr_b,
    output logic                  r_valid,
    output logic [DATA_WIDTH-1:0] r_data_a,
    output logic [DATA_WIDTH-1:0] r_data_b,
    output logic                  stall
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic                  r_valid_q;
    logic                  r_valid_d;
    logic [DATA_WIDTH-1:0] r_data_a_q;
    logic [DATA_WIDTH-1:0] r_data_a_d;
    logic [DATA_WIDTH-1:0] r_data_b_q;
    logic [DATA_WIDTH-1:0] r_data_b_d;

    logic                  w_live;
    logic                  bypass_a;
    logic                  bypass_b;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_val_a;
    logic [DATA_WIDTH-1:0] rd_val_b;

    // Operand selection, bypass detection and scoreboard stall (pre-issue busy view)
    always_comb begin
        w_live   = w_enable && (w_addr != '0);
        bypass_a = w_live && (w_addr == r_addr_a);
        bypass_b = w_live && (w_addr == r_addr_b);
        stall    = r_req && ((busy_q[r_addr_a] && !bypass_a) ||
                             (busy_q[r_addr_b] && !bypass_b));
        rd_fire  = r_req && !stall;

        if (r_addr_a == '0) begin
            rd_val_a = '0;
        end else if (bypass_a) begin
            rd_val_a = w_data;
        end else begin
            rd_val_a = mem_q[r_addr_a];
        end

        if (r_addr_b == '0) begin
            rd_val_b = '0;
        end else if (bypass_b) begin
            rd_val_b = w_data;
        end else begin
            rd_val_b = mem_q[r_addr_b];
        end
    end

    // Next state: writeback updates storage and clears busy; issue sets busy last so it wins
    always_comb begin
        mem_d      = mem_q;
        busy_d     = busy_q;
        r_valid_d  = rd_fire;
        r_data_a_d = r_data_a_q;
        r_data_b_d = r_data_b_q;

        if (w_live) begin
            mem_d[w_addr]  = w_data;
            busy_d[w_addr] = 1'b0;
        end
        if (issue_valid && (issue_addr != '0)) begin
            busy_d[issue_addr] = 1'b1;
        end
        if (rd_fire) begin
            r_data_a_d = rd_val_a;
            r_data_b_d = rd_val_b;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            r_valid_q  <= 1'b0;
            r_data_a_q <= '0;
            r_data_b_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q     <= busy_d;
            r_valid_q  <= r_valid_d;
            r_data_a_q <= r_data_a_d;
            r_data_b_q <= r_data_b_d;
        end
    end

    assign r_valid  = r_valid_q;
    assign r_data_a = r_data_a_q;
    assign r_data_b = r_data_b_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port: reset, write/read, bypass, scoreboard,
// issue/write collision, x0 protection and back-to-back traffic.
module tb_regfile_read_port;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clock;
    logic          reset_n;
    logic          w_enable;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          issue_valid;
    logic [AW-1:0] issue_addr;
    logic          r_req;
    logic [AW-1:0] r_addr_a;
    logic [AW-1:0] r_addr_b;
    logic          r_valid;
    logic [DW-1:0] r_data_a;
    logic [DW-1:0] r_data_b;
    logic          stall;

    int vectors;
    int miscompares;

    regfile_read_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .w_enable    (w_enable),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .r_req       (r_req),
        .r_addr_a    (r_addr_a),
        .r_addr_b    (r_addr_b),
        .r_valid     (r_valid),
        .r_data_a    (r_data_a),
        .r_data_b    (r_data_b),
        .stall       (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        w_enable    = 1'b0;
        w_addr      = '0;
        w_data      = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        r_req       = 1'b0;
        r_addr_a    = '0;
        r_addr_b    = '0;
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (r_valid !== 1'b0 || r_data_a !== '0 || r_data_b !== '0) begin
            miscompares++;
            $display("FAIL reset_init: valid=%0b a=%h b=%h, want 0/0/0", r_valid, r_data_a, r_data_b);
        end
        reset_n = 1'b1;
        // populate x5, then read it so outputs are non-zero before mid-run reset
        w_enable = 1'b1; w_addr = 5'd5; w_data = 32'h0000_0055;
        tick();
        idle();
        r_req = 1'b1; r_addr_a = 5'd5; r_addr_b = 5'd5;
        tick();
        vectors++;
        if (r_valid !== 1'b1 || r_data_a !== 32'h55 || r_data_b !== 32'h55) begin
            miscompares++;
            $display("FAIL pre_reset_read: valid=%0b a=%h b=%h, want 1/55/55", r_valid, r_data_a, r_data_b);
        end
        idle();
        reset_n = 1'b0;
        #1;
        vectors++;
        if (r_valid !== 1'b0 || r_data_a !== '0 || r_data_b !== '0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%0b a=%h b=%h, want 0/0/0", r_valid, r_data_a, r_data_b);
        end
        tick();
        reset_n = 1'b1;
        r_req = 1'b1; r_addr_a = 5'd5; r_addr_b = 5'd6;
        tick();
        vectors++;
        if (r_valid !== 1'b1 || r_data_a !== '0 || r_data_b !== '0) begin
            miscompares++;
            $display("FAIL post_reset_read: valid=%0b a=%h b=%h, want 1/0/0", r_valid, r_data_a, r_data_b);
        end
        idle();
        tick();
    endtask

    task automatic test_write_read();
        w_enable = 1'b1; w_addr = 5'd3; w_data = 32'd31;
        tick();
        idle();
        r_req = 1'b1; r_addr_a = 5'd3; r_addr_b = 5'd0;
        tick();
        vectors++;
        if (r_valid !== 1'b1 || r_data_a !== 32'd31 || r_data_b !== 32'd0) begin
            miscompares++;
            $display("FAIL write_read: valid=%0b a=%0d b=%0d, want 1/31/0", r_valid, r_data_a, r_data_b);
        end
        idle();
        tick();
        vectors++;
        if (r_valid !== 1'b0 || r_data_a !== 32'd31) begin
            miscompares++;
            $display("FAIL hold_idle: valid=%0b a=%0d, want 0/31", r_valid, r_data_a);
        end
    endtask

    task automatic test_bypass();
        w_enable = 1'b1; w_addr = 5'd7; w_data = 32'd127;
        r_req = 1'b1; r_addr_a = 5'd7; r_addr_b = 5'd7;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_stall: stall=%0b, want 0", stall);
        end
        tick();
        vectors++;
        if (r_valid !== 1'b1 || r_data_a !== 32'd127 || r_data_b !== 32'd127) begin
            miscompares++;
            $display("FAIL bypass_data: valid=%0b a=%0d b=%0d, want 1/127/127", r_valid, r_data_a, r_data_b);
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_addr = 5'd9;
        tick();
        idle();
        r_req = 1'b1; r_addr_a = 5'd9; r_addr_b = 5'd0;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_stall: stall=%0b, want 1", stall);
        end
        tick();
        vectors++;
        if (r_valid !== 1'b0 || r_data_a !== 32'd127) begin
            miscompares++;
            $display("FAIL sb_stalled_out: valid=%0b a=%0d, want 0/127 (held)", r_valid, r_data_a);
        end
        w_enable = 1'b1; w_addr = 5'd9; w_data = 32'd1023;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_release_stall: stall=%0b, want 0", stall);
        end
        tick();
        vectors++;
        if (r_valid !== 1'b1 || r_data_a !== 32'd1023) begin
            miscompares++;
            $display("FAIL sb_release_data: valid=%0b a=%0d, want 1/1023", r_valid, r_data_a);
        end
        // port B stalls too
        idle();
        issue_valid = 1'b1; issue_addr = 5'd10;
        tick();
        idle();
        r_req = 1'b1; r_addr_a = 5'd0; r_addr_b = 5'd10;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_port_b_stall: stall=%0b, want 1", stall);
        end
        idle();
        w_enable = 1'b1; w_addr = 5'd10; w_data = 32'h0000_00A0;
        tick();
        idle();
        r_req = 1'b1; r_addr_a = 5'd9; r_addr_b = 5'd10;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_cleared_stall: stall=%0b, want 0", stall);
        end
        tick();
        vectors++;
        if (r_valid !== 1'b1 || r_data_a !== 32'd1023 || r_data_b !== 32'h0A0) begin
            miscompares++;
            $display("FAIL sb_cleared_data: valid=%0b a=%0d b=%h, want 1/1023/a0", r_valid, r_data_a, r_data_b);
        end
        idle();
        tick();
    endtask

    task automatic test_collision();
        issue_valid = 1'b1; issue_addr = 5'd4;
        w_enable = 1'b1; w_addr = 5'd4; w_data = 32'd5;
        tick();
        idle();
        r_req = 1'b1; r_addr_a = 5'd4; r_addr_b = 5'd0;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL collide_stall: stall=%0b, want 1", stall);
        end
        tick();
        vectors++;
        if (r_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_valid: valid=%0b, want 0", r_valid);
        end
        w_enable = 1'b1; w_addr = 5'd4; w_data = 32'd6;
        tick();
        vectors++;
        if (r_valid !== 1'b1 || r_data_a !== 32'd6) begin
            miscompares++;
            $display("FAIL collide_data: valid=%0b a=%0d, want 1/6", r_valid, r_data_a);
        end
        idle();
        tick();
    endtask

    task automatic test_x0();
        w_enable = 1'b1; w_addr = 5'd0; w_data = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_addr = 5'd0;
        tick();
        idle();
        // also try a same-cycle write to x0 while reading it
        w_enable = 1'b1; w_addr = 5'd0; w_data = 32'hFFFF_FFFF;
        r_req = 1'b1; r_addr_a = 5'd0; r_addr_b = 5'd0;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_stall: stall=%0b, want 0", stall);
        end
        tick();
        vectors++;
        if (r_valid !== 1'b1 || r_data_a !== '0 || r_data_b !== '0) begin
            miscompares++;
            $display("FAIL x0_data: valid=%0b a=%h b=%h, want 1/0/0", r_valid, r_data_a, r_data_b);
        end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        w_enable = 1'b1; w_addr = 5'd11; w_data = 32'h0000_0111;
        tick();
        w_addr = 5'd12; w_data = 32'h0000_0222;
        r_req = 1'b1; r_addr_a = 5'd11; r_addr_b = 5'd12;
        tick();
        vectors++;
        if (r_valid !== 1'b1 || r_data_a !== 32'h111 || r_data_b !== 32'h222) begin
            miscompares++;
            $display("FAIL b2b_first: valid=%0b a=%h b=%h, want 1/111/222", r_valid, r_data_a, r_data_b);
        end
        // read swaps ports; issue of x13 in same cycle as read of x13 does not stall it
        w_enable = 1'b0;
        r_addr_a = 5'd12; r_addr_b = 5'd13;
        issue_valid = 1'b1; issue_addr = 5'd13;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_issue_same_cycle: stall=%0b, want 0", stall);
        end
        tick();
        vectors++;
        if (r_valid !== 1'b1 || r_data_a !== 32'h222 || r_data_b !== 32'h0) begin
            miscompares++;
            $display("FAIL b2b_second: valid=%0b a=%h b=%h, want 1/222/0", r_valid, r_data_a, r_data_b);
        end
        issue_valid = 1'b0;
        r_addr_a = 5'd11; r_addr_b = 5'd13;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_busy_after_issue: stall=%0b, want 1", stall);
        end
        idle();
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_x0();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Two-read / one-write 32-entry register file for the RISC-V core feeding CGRA tiles.
- Consumer side of the per-register write interface: writeback units push value/enable; this block serves operand reads.
- Includes write-to-read bypass and a per-register busy scoreboard that stalls reads of registers with an outstanding writeback.
- x0 is hardwired zero.

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH entries).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- w_enable  input  1  writeback strobe.
- w_addr  input  ADDR_WIDTH  writeback register index.
- w_data  input  DATA_WIDTH  writeback value.
- issue_valid  input  1  instruction issued that will write issue_addr.
- issue_addr  input  ADDR_WIDTH  destination register being reserved.
- r_req  input  1  operand read request.
- r_addr_a  input  ADDR_WIDTH  source A index.
- r_addr_b  input  ADDR_WIDTH  source B index.
- r_valid  output  1  registered: operands valid this cycle.
- r_data_a  output  DATA_WIDTH  registered source A value.
- r_data_b  output  DATA_WIDTH  registered source B value.
- stall  output  1  combinational: current r_req blocked by scoreboard.

Behaviour:
Reset (reset_n low, asynchronous):
- All registers, busy bits, r_valid, r_data_a and r_data_b go to 0 immediately.
- They are held at 0 while reset_n is low.
- Reset mid-operation discards pending reservations; nothing is replayed.

Write:
- On a clock edge with w_enable=1 and w_addr!=0: mem[w_addr] <= w_data, and busy[w_addr] clears.
- A write to x0 is ignored. busy[0] is never set.

Issue / scoreboard:
- On a clock edge with issue_valid=1 and issue_addr!=0: busy[issue_addr] sets.
- Issue and writeback to the same register on the same edge: issue wins, so busy stays 1. This models a new producer.
- Issue to a register that is already busy is legal; busy stays 1. A single bit is used, with no counting.

Read:
- stall = r_req & ((busy[r_addr_a] & ~bypass_a) | (busy[r_addr_b] & ~bypass_b)).
- bypass_x = w_enable & (w_addr==r_addr_x) & (r_addr_x!=0).
- Busy is evaluated before this cycle's issue takes effect.
- On a clock edge with r_req=1 and stall=0:
  - r_valid <= 1.
  - r_data_x <= 0 if r_addr_x==0; else w_data if bypass_x; else mem[r_addr_x].
- Otherwise r_valid <= 0, and r_data_a / r_data_b hold their previous values.
- Latency is 1 cycle from request edge to r_valid.
- Both ports may name the same register. Each port reads independently; bypass applies to both.

State summary:
- mem: 31 live registers.
- busy: 31 bits.
- Output registers: r_valid, r_data_a, r_data_b.
- No further FSM states.

Test Plan:
- Reset then read: assert reset_n=0 mid-run with r_valid=1 -> r_valid, r_data_a and r_data_b are 0 immediately, before the next clock edge. Release, read x5/x6 -> r_valid=1, both data 0.
- Write then read: write x3=31 at edge N, read a=x3, b=x0 at edge N+1 -> at N+2 r_data_a=31, r_data_b=0, r_valid=1.
- Bypass: same cycle w_enable, w_addr=7, w_data=127, r_req with a=b=7 -> next cycle r_data_a=r_data_b=127, stall=0.
- Scoreboard: issue x9; next cycle r_req a=x9 -> stall=1, r_valid=0 after the edge. Write x9=1023 with r_req still high -> stall=0 that cycle, r_data_a=1023 next cycle.
- Issue+write collision: issue x4 and write x4=5 on the same edge; then r_req a=x4 without a write -> stall=1. A later write of x4=6 clears it, and the read returns 6.
- x0 protection: write x0=0xFFFFFFFF and issue x0 -> read x0 gives 0, stall=0.
